// File: rtl/img_pkg.sv
// Shared definitions for the UART image loader: FSM encoding, protocol bytes, checksum step.
package img_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMD  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_CSUM = 2'd3;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;
   localparam logic [7:0] CMD_LOAD_DEF  = 8'h01;

   // Running frame checksum: plain byte-wise XOR.
   function automatic logic [7:0] csum_step(input logic [7:0] csum, input logic [7:0] b);
      return csum ^ b;
   endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte watchdog: counts while enabled, restarts on clear, pulses expired for one cycle.
module byte_timeout #(
   parameter int unsigned TIMEOUT_CYC = 120000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expired_q, expired_d;

   // Next count; wrapping to zero on expiry keeps the pulse single-cycle.
   always_comb begin
      cnt_d     = cnt_q;
      expired_d = 1'b0;
      if (clear || !enable) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
         cnt_d     = '0;
         expired_d = 1'b1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter and pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         expired_q <= expired_d;
      end
   end

   assign expired = expired_q;

endmodule

// File: rtl/uart_img_ctrl.sv
// Frame loader: parses SYNC/CMD/pixels/checksum from a UART byte stream into a
// double-buffered framebuffer and swaps banks on the next vertical blank.
module uart_img_ctrl import img_pkg::*; #(
   parameter int unsigned PIX_COUNT   = 4800,
   parameter int unsigned ADDR_W      = 13,
   parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
   parameter logic [7:0]  CMD_LOAD    = CMD_LOAD_DEF,
   parameter int unsigned TIMEOUT_CYC = 120000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_rdy,
   input  logic              vsync_start,
   output logic              wr_en,
   output logic              wr_bank,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              disp_bank,
   output logic              frame_done,
   output logic              err,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIX_COUNT - 1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [7:0]        csum_q, csum_d;
   logic              swap_pending_q, swap_pending_d;
   logic              disp_bank_q, disp_bank_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              frame_done_q, frame_done_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              timeout_active;
   logic              expired;

   assign timeout_active = (state_q != ST_IDLE);

   byte_timeout #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (rx_rdy),
      .enable  (timeout_active),
      .expired (expired)
   );

   // Next-state: bank swap on vblank, then byte parsing (a byte beats a timeout).
   always_comb begin
      state_d        = state_q;
      pix_cnt_d      = pix_cnt_q;
      csum_d         = csum_q;
      swap_pending_d = swap_pending_q;
      disp_bank_d    = disp_bank_q;
      wr_en_d        = 1'b0;
      wr_addr_d      = wr_addr_q;
      wr_data_d      = wr_data_q;
      frame_done_d   = 1'b0;
      err_d          = err_q;

      // A swap armed by the frame_done visible this cycle waits for the next vblank.
      if (vsync_start && swap_pending_q && !frame_done_q) begin
         disp_bank_d    = ~disp_bank_q;
         swap_pending_d = 1'b0;
      end

      if (rx_rdy) begin
         case (state_q)
            ST_IDLE: begin
               if (!swap_pending_q && rx_data == SYNC_BYTE) begin
                  state_d = ST_CMD;
                  err_d   = 1'b0;
               end
            end
            ST_CMD: begin
               if (rx_data == CMD_LOAD) begin
                  state_d   = ST_DATA;
                  pix_cnt_d = '0;
                  csum_d    = '0;
               end else begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end
            end
            ST_DATA: begin
               wr_en_d   = 1'b1;
               wr_addr_d = pix_cnt_q;
               wr_data_d = rx_data;
               csum_d    = csum_step(csum_q, rx_data);
               if (pix_cnt_q == LAST_PIX) begin
                  state_d = ST_CSUM;
               end else begin
                  pix_cnt_d = pix_cnt_q + ADDR_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               if (rx_data == csum_q) begin
                  frame_done_d   = 1'b1;
                  swap_pending_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         endcase
      end else if (expired && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
      end

      busy_d = (state_d != ST_IDLE) || swap_pending_d;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         pix_cnt_q      <= '0;
         csum_q         <= '0;
         swap_pending_q <= 1'b0;
         disp_bank_q    <= 1'b0;
         wr_en_q        <= 1'b0;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
         frame_done_q   <= 1'b0;
         err_q          <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         pix_cnt_q      <= pix_cnt_d;
         csum_q         <= csum_d;
         swap_pending_q <= swap_pending_d;
         disp_bank_q    <= disp_bank_d;
         wr_en_q        <= wr_en_d;
         wr_addr_q      <= wr_addr_d;
         wr_data_q      <= wr_data_d;
         frame_done_q   <= frame_done_d;
         err_q          <= err_d;
         busy_q         <= busy_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_bank    = ~disp_bank_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign disp_bank  = disp_bank_q;
   assign frame_done = frame_done_q;
   assign err        = err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_img_ctrl.sv
// Directed bench for uart_img_ctrl with a write scoreboard (PIX_COUNT=4, TIMEOUT_CYC=200).
module tb_uart_img_ctrl;

   localparam int unsigned PIX_COUNT   = 4;
   localparam int unsigned ADDR_W      = 2;
   localparam int unsigned TIMEOUT_CYC = 200;

   typedef struct packed {
      logic              bank;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        rx_data;
   logic              rx_rdy;
   logic              vsync_start;
   logic              wr_en;
   logic              wr_bank;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              disp_bank;
   logic              frame_done;
   logic              err;
   logic              busy;

   int  checks   = 0;
   int  errors   = 0;
   int  fd_cnt   = 0;
   wr_t exp_q[$];

   uart_img_ctrl #(
      .PIX_COUNT   (PIX_COUNT),
      .ADDR_W      (ADDR_W),
      .SYNC_BYTE   (8'hAA),
      .CMD_LOAD    (8'h01),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_rdy      (rx_rdy),
      .vsync_start (vsync_start),
      .wr_en       (wr_en),
      .wr_bank     (wr_bank),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .disp_bank   (disp_bank),
      .frame_done  (frame_done),
      .err         (err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (rst === 1'b1 && wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("wr_unexpected", 32'(wr_en), 32'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_bank", 32'(wr_bank), 32'(e.bank));
            chk("wr_addr", 32'(wr_addr), 32'(e.addr));
            chk("wr_data", 32'(wr_data), 32'(e.data));
         end
      end
      if (rst === 1'b1 && frame_done === 1'b1) fd_cnt++;
   end

   task automatic send_byte(input logic [7:0] b, input int idle);
      @(negedge clk);
      rx_data = b;
      rx_rdy  = 1'b1;
      @(negedge clk);
      rx_rdy  = 1'b0;
      repeat (idle) @(negedge clk);
   endtask

   task automatic pulse_vsync();
      @(negedge clk);
      vsync_start = 1'b1;
      @(negedge clk);
      vsync_start = 1'b0;
   endtask

   // Full frame; the checksum byte is the XOR of the pixels, then XOR-ed with cs_mask.
   // With vs_coincide, vsync_start is raised in the cycle frame_done is visible.
   task automatic send_frame(input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] p3,
                             input logic bank, input logic [7:0] cs_mask,
                             input int gap, input logic vs_coincide);
      logic [7:0] px[4];
      logic [7:0] cs;
      wr_t        e;
      px = '{p0, p1, p2, p3};
      cs = 8'h00;
      send_byte(8'hAA, 2);
      send_byte(8'h01, 2);
      for (int i = 0; i < 4; i++) begin
         e.bank = bank;
         e.addr = ADDR_W'(i);
         e.data = px[i];
         exp_q.push_back(e);
         cs = cs ^ px[i];
         send_byte(px[i], (i == 1) ? gap : 2);
      end
      if (vs_coincide) begin
         @(negedge clk);
         rx_data = cs ^ cs_mask;
         rx_rdy  = 1'b1;
         @(negedge clk);
         rx_rdy      = 1'b0;
         vsync_start = 1'b1;
         @(negedge clk);
         vsync_start = 1'b0;
         repeat (2) @(negedge clk);
      end else begin
         send_byte(cs ^ cs_mask, 4);
      end
   endtask

   initial begin
      wr_t e;
      rst         = 1'b0;
      rx_data     = 8'h00;
      rx_rdy      = 1'b0;
      vsync_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_wr_en",      32'(wr_en),      32'd0);
      chk("rst_wr_addr",    32'(wr_addr),    32'd0);
      chk("rst_wr_data",    32'(wr_data),    32'd0);
      chk("rst_disp_bank",  32'(disp_bank),  32'd0);
      chk("rst_wr_bank",    32'(wr_bank),    32'd1);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_err",        32'(err),        32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Valid frame into bank 1.
      send_frame(8'h10, 8'h20, 8'h30, 8'h40, 1'b1, 8'h00, 2, 1'b0);
      chk("f1_done_cnt", 32'(fd_cnt), 32'd1);
      chk("f1_err",      32'(err), 32'd0);
      chk("f1_busy",     32'(busy), 32'd1);
      chk("f1_disp",     32'(disp_bank), 32'd0);
      chk("f1_q_empty",  32'(exp_q.size()), 32'd0);

      // Pending swap: a new SYNC must be ignored (any write would be unexpected).
      send_byte(8'hAA, 2);
      send_byte(8'h01, 2);
      send_byte(8'h10, 4);
      chk("pend_err",  32'(err), 32'd0);
      chk("pend_busy", 32'(busy), 32'd1);

      pulse_vsync();
      chk("swap1_disp",  32'(disp_bank), 32'd1);
      chk("swap1_wbank", 32'(wr_bank), 32'd0);
      chk("swap1_busy",  32'(busy), 32'd0);
      pulse_vsync();
      chk("noswap_disp", 32'(disp_bank), 32'd1);

      // Bad checksum into bank 0.
      send_frame(8'h10, 8'h20, 8'h30, 8'h40, 1'b0, 8'h40, 2, 1'b0);
      chk("bad_err",      32'(err), 32'd1);
      chk("bad_done_cnt", 32'(fd_cnt), 32'd1);
      chk("bad_disp",     32'(disp_bank), 32'd1);
      chk("bad_busy",     32'(busy), 32'd0);
      chk("bad_q_empty",  32'(exp_q.size()), 32'd0);

      // Bad command, then SYNC clears err.
      send_byte(8'hAA, 2);
      send_byte(8'h02, 2);
      chk("cmd_err",  32'(err), 32'd1);
      chk("cmd_busy", 32'(busy), 32'd0);
      send_byte(8'hAA, 2);
      chk("sync_clr_err", 32'(err), 32'd0);
      chk("sync_busy",    32'(busy), 32'd1);
      send_byte(8'h02, 2);
      chk("cmd2_err", 32'(err), 32'd1);

      // Stall inside DATA past the timeout.
      e.bank = 1'b0; e.addr = '0; e.data = 8'h10;
      exp_q.push_back(e);
      send_byte(8'hAA, 2);
      send_byte(8'h01, 2);
      send_byte(8'h10, 250);
      chk("to_err",     32'(err), 32'd1);
      chk("to_busy",    32'(busy), 32'd0);
      chk("to_q_empty", 32'(exp_q.size()), 32'd0);

      // Recovery frame; one gap lands a byte on the same cycle as the timeout pulse.
      send_frame(8'h55, 8'h66, 8'h77, 8'h88, 1'b0, 8'h00, 199, 1'b0);
      chk("rec_done_cnt", 32'(fd_cnt), 32'd2);
      chk("rec_err",      32'(err), 32'd0);
      chk("rec_q_empty",  32'(exp_q.size()), 32'd0);
      pulse_vsync();
      chk("swap2_disp", 32'(disp_bank), 32'd0);
      chk("swap2_busy", 32'(busy), 32'd0);

      // frame_done coinciding with vsync_start: swap waits for the next vblank.
      send_frame(8'h01, 8'h02, 8'h04, 8'h08, 1'b1, 8'h00, 2, 1'b1);
      chk("coin_done_cnt", 32'(fd_cnt), 32'd3);
      chk("coin_disp",     32'(disp_bank), 32'd0);
      chk("coin_busy",     32'(busy), 32'd1);
      pulse_vsync();
      chk("swap3_disp", 32'(disp_bank), 32'd1);
      chk("swap3_busy", 32'(busy), 32'd0);

      // Reset in the middle of DATA.
      e.bank = 1'b0; e.addr = 2'd0; e.data = 8'h10;
      exp_q.push_back(e);
      e.addr = 2'd1; e.data = 8'h20;
      exp_q.push_back(e);
      send_byte(8'hAA, 2);
      send_byte(8'h01, 2);
      send_byte(8'h10, 2);
      send_byte(8'h20, 2);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_wr_en",  32'(wr_en), 32'd0);
      chk("mrst_addr",   32'(wr_addr), 32'd0);
      chk("mrst_data",   32'(wr_data), 32'd0);
      chk("mrst_disp",   32'(disp_bank), 32'd0);
      chk("mrst_err",    32'(err), 32'd0);
      chk("mrst_busy",   32'(busy), 32'd0);
      chk("mrst_fdone",  32'(frame_done), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      send_byte(8'h30, 2);
      send_byte(8'h40, 4);
      chk("post_rst_q_empty", 32'(exp_q.size()), 32'd0);
      chk("post_rst_disp",    32'(disp_bank), 32'd0);
      chk("post_rst_done",    32'(fd_cnt), 32'd3);
      chk("post_rst_busy",    32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
